// File: rtl/cdc_handshake_tx_pkg.sv
// Shared handshake state encoding for the req/ack crossing pair (tx and rx).
`default_nettype none

package cdc_handshake_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hs_state_e;

endpackage

`default_nettype wire

// File: rtl/cdc_handshake_tx_sync.sv
// Multi-flop synchroniser with async reset; q is d delayed by STAGES clk edges.
`default_nettype none

module cdc_handshake_tx_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[STAGES-2:0], d};
    end
  end

  assign q = pipe[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack word crossing: latch word, raise req,
// wait for synchronised ack, drop req, wait for ack low, pulse done.
`default_nettype none

module cdc_handshake_tx
  import cdc_handshake_tx_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0,
  parameter int TO_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             xfer_req,
  output logic [WIDTH-1:0] xfer_data,
  input  logic             xfer_ack,
  output logic             xfer_done,
  output logic             ack_timeout
);

  hs_state_e state, state_nx;
  logic      req_nx;
  logic      done_nx;
  logic      load;
  logic      ack_s;

  cdc_handshake_tx_sync #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (xfer_ack),
    .q     (ack_s)
  );

  assign in_ready = (state == IDLE) & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      xfer_req  <= 1'b0;
      xfer_data <= '0;
      xfer_done <= 1'b0;
    end else begin
      state     <= state_nx;
      xfer_req  <= req_nx;
      xfer_done <= done_nx;
      if (load) begin
        xfer_data <= in_data;
      end
    end
  end

  // A stale ack already high on entry to REQ is taken as the ack.
  always_comb begin
    state_nx = state;
    req_nx   = xfer_req;
    done_nx  = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_nx = REQ;
          req_nx   = 1'b1;
          load     = 1'b1;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_nx = REL;
          req_nx   = 1'b0;
        end
      end
      REL: begin
        if (!ack_s) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

  if (TIMEOUT != 0) begin : g_timeout
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT);

    logic [TO_W-1:0] to_cnt;
    logic            waiting;
    logic            stay;

    assign waiting = (state == REQ) || (state == REL);
    assign stay    = (state_nx == state);

    // Saturating one past the trigger value keeps the pulse single per phase.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        to_cnt      <= '0;
        ack_timeout <= 1'b0;
      end else begin
        ack_timeout <= waiting && stay && (to_cnt == TO_LAST);
        if (!stay) begin
          to_cnt <= '0;
        end else if (waiting && (to_cnt != TO_SAT)) begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
    end
  end else begin : g_no_timeout
    assign ack_timeout = 1'b0;
  end

  a_data_stable : assert property (
    @(posedge clk) disable iff (reset)
    (xfer_req | ack_s) |=> $stable(xfer_data)
  );

  // The destination must have returned ack low before a new request starts.
  a_no_stale_ack : assert property (
    @(posedge clk) disable iff (reset)
    (in_valid & in_ready) |-> !ack_s
  );

endmodule

`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
// Randomised bench for cdc_handshake_tx with an ack BFM and a phase-level reference model.
`default_nettype none

module tb_cdc_handshake_tx;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int TOUT  = 8;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             xfer_req;
  logic [WIDTH-1:0] xfer_data;
  logic             xfer_ack;
  logic             xfer_done;
  logic             ack_timeout;

  cdc_handshake_tx #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC),
    .TIMEOUT     (TOUT),
    .TO_W        (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .xfer_req    (xfer_req),
    .xfer_data   (xfer_data),
    .xfer_ack    (xfer_ack),
    .xfer_done   (xfer_done),
    .ack_timeout (ack_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ack BFM: follows req after a delay, optionally never acknowledging.
  bit ack_never = 1'b0;
  bit rand_dly  = 1'b0;
  int fix_dly   = 3;

  initial begin
    int cnt;
    int dly;
    xfer_ack = 1'b0;
    cnt = 0;
    dly = 3;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        xfer_ack = 1'b0;
        cnt = 0;
      end else if ((xfer_req != xfer_ack) && !(ack_never && xfer_req)) begin
        cnt++;
        if (cnt >= dly) begin
          xfer_ack = xfer_req;
          cnt = 0;
          dly = rand_dly ? int'($urandom_range(0, 12)) : fix_dly;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Reference model: phase 0 = idle, 1 = awaiting ack high, 2 = awaiting ack low.
  // The locally seen ack is the raw ack as it stood SYNC edges earlier.
  int               m_phase = 0;
  logic [WIDTH-1:0] m_data  = '0;
  bit               m_done  = 1'b0;
  bit               m_to    = 1'b0;
  int               m_age   = 0;
  bit               ack_hist[$];

  int cyc = 0;
  int acc_cyc = -1, rise_cyc = -1, done_cyc = -1, to_cyc = -1;
  int n_done = 0, n_to = 0;
  logic [WIDTH-1:0] rise_words[$];
  logic prev_req = 1'b0;

  initial begin
    for (int i = 0; i < SYNC; i++) ack_hist.push_back(1'b0);
  end

  always @(negedge clk) begin
    int  nphase;
    bit  seen_ack;
    cyc++;
    if (reset) begin
      m_phase = 0;
      m_data  = '0;
      m_done  = 1'b0;
      m_to    = 1'b0;
      m_age   = 0;
      for (int i = 0; i < SYNC; i++) ack_hist[i] = 1'b0;
    end
    chk("in_ready",    32'(in_ready),    32'(m_phase == 0 && !reset));
    chk("xfer_req",    32'(xfer_req),    32'(m_phase == 1));
    chk("xfer_data",   xfer_data,        m_data);
    chk("xfer_done",   32'(xfer_done),   32'(m_done));
    chk("ack_timeout", 32'(ack_timeout), 32'(m_to));

    if (xfer_req && !prev_req) begin
      rise_cyc = cyc;
      rise_words.push_back(xfer_data);
    end
    if (xfer_done) begin
      done_cyc = cyc;
      n_done++;
    end
    if (ack_timeout) begin
      to_cyc = cyc;
      n_to++;
    end
    prev_req = xfer_req;

    if (!reset) begin
      if (in_valid && in_ready) acc_cyc = cyc;
      seen_ack = ack_hist[0];
      nphase = m_phase;
      m_done = 1'b0;
      if (m_phase == 0 && in_valid) begin
        nphase = 1;
        m_data = in_data;
      end else if (m_phase == 1 && seen_ack) begin
        nphase = 2;
      end else if (m_phase == 2 && !seen_ack) begin
        nphase = 0;
        m_done = 1'b1;
      end
      m_to  = (m_phase != 0) && (nphase == m_phase) && (m_age == TOUT - 1);
      m_age = (nphase == m_phase) ? m_age + 1 : 0;
      m_phase = nphase;
      void'(ack_hist.pop_front());
      ack_hist.push_back(xfer_ack);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_from(input int base, input int max_cyc);
    int n = 0;
    while (n_done == base && n < max_cyc) begin
      tick();
      n++;
    end
    if (n_done == base) chk("wait_done_bound", 32'(n), 32'(-1));
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int base_done, base_rise, base_to, n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    tick(); tick(); tick();
    reset = 1'b0;

    // Idle after reset
    repeat (10) tick();
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_req",   32'(xfer_req), 32'd0);
    chk("idle_data",  xfer_data,     32'd0);
    chk("idle_pulses", 32'(n_done + n_to), 32'd0);

    // Single word, ack 3 cycles after req
    base_done = n_done;
    base_rise = rise_words.size();
    send(32'hDEADBEEF);
    wait_done_from(base_done, 100);
    repeat (5) tick();
    chk("single_done_count", 32'(n_done - base_done), 32'd1);
    chk("single_req_latency", 32'(rise_cyc - acc_cyc), 32'd1);
    chk("single_word", rise_words[base_rise], 32'hDEADBEEF);

    // Back-to-back with valid held
    base_done = n_done;
    base_rise = rise_words.size();
    in_valid = 1'b1;
    in_data  = 32'h1;
    tick();
    tick();
    in_data = 32'h2;
    n = 0;
    while (rise_words.size() < base_rise + 2 && n < 200) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("b2b_gap", 32'(rise_cyc - done_cyc), 32'd1);
    wait_done_from(base_done + 1, 100);
    repeat (5) tick();
    chk("b2b_rises", 32'(rise_words.size() - base_rise), 32'd2);
    chk("b2b_first",  rise_words[base_rise],     32'h1);
    chk("b2b_second", rise_words[base_rise + 1], 32'h2);

    // Timeout with no ack, then late ack completes
    base_done = n_done;
    base_to   = n_to;
    ack_never = 1'b1;
    send(32'hCAFE0004);
    n = 0;
    while (n_to == base_to && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_offset", 32'(to_cyc - rise_cyc), 32'd8);
    repeat (5) tick();
    ack_never = 1'b0;
    wait_done_from(base_done, 100);
    repeat (5) tick();
    chk("timeout_pulses", 32'(n_to - base_to), 32'd1);
    chk("timeout_done",   32'(n_done - base_done), 32'd1);

    // Reset while in REQ
    ack_never = 1'b1;
    send(32'h55AA55AA);
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_req_async",  32'(xfer_req), 32'd0);
    chk("rst_data_async", xfer_data,     32'd0);
    tick(); tick();
    ack_never = 1'b0;
    reset = 1'b0;
    tick();
    base_done = n_done;
    send(32'h0BADF00D);
    wait_done_from(base_done, 100);
    chk("rst_next_word", rise_words[rise_words.size() - 1], 32'h0BADF00D);

    // in_valid during REL is ignored
    repeat (3) tick();
    base_done = n_done;
    base_rise = rise_words.size();
    send(32'h12345678);
    n = 0;
    while (!(xfer_req == 1'b0 && dut.state == cdc_handshake_tx_pkg::REL) && n < 50) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    in_data  = 32'hAA;
    tick(); tick();
    in_valid = 1'b0;
    chk("rel_data_held", xfer_data, 32'h12345678);
    wait_done_from(base_done, 100);
    repeat (5) tick();
    chk("rel_no_extra_req", 32'(rise_words.size() - base_rise), 32'd1);

    // Randomised traffic, ack latency and occasional reset
    rand_dly = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        in_valid = 1'b0;
        reset = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    repeat (60) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
